// File: rtl/bubble_sorter_pkg.sv
// -----------------------------------------------------------------------------
// sorter_pkg
// Shared definitions for the bubble_sorter block:
//   sort_state_t : the seven FSM states of the sorter
//   calc_aw()    : address width for a given array depth
//   calc_cw()    : width of the swap counter (enough for the worst-case
//                  DEPTH*(DEPTH-1)/2 swaps of a reversed array)
// -----------------------------------------------------------------------------
package sorter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LDA,
        LDB,
        CMP,
        WRA,
        WRB,
        DONE
    } sort_state_t;

    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_cw(input int depth);
        return $clog2(depth * (depth - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/bubble_sorter_if.sv
// -----------------------------------------------------------------------------
// bubble_sorter_if
// Host-side bundle of the sorter.
//   start, descend        : sort request and direction (host -> sorter)
//   wr_en/wr_addr/wr_data : host write port into the word store
//   rd_addr/rd_data       : host combinational read port
//   busy, done, swap_cnt  : status back to the host
// The sorter uses the slave modport, the host logic the master modport.
// -----------------------------------------------------------------------------
interface bubble_sorter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int AW = sorter_pkg::calc_aw(DEPTH);
    localparam int CW = sorter_pkg::calc_cw(DEPTH);

    logic             start;
    logic             descend;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic [CW-1:0]    swap_cnt;

    modport slave (
        input  start, descend, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, done, swap_cnt
    );

    modport master (
        output start, descend, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done, swap_cnt
    );
endinterface

// File: rtl/bubble_sorter_mem.sv
// -----------------------------------------------------------------------------
// sort_mem
// DEPTH x WIDTH word store for the sorter. No reset: contents survive a
// sorter reset.
//   clk       : clock
//   we_i      : write enable (already muxed host / FSM by the caller)
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_a_i : FSM operand read address  -> rdata_a_o (combinational)
//   raddr_b_i : host read address         -> rdata_b_o (combinational)
// -----------------------------------------------------------------------------
module sort_mem
    import sorter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/bubble_sorter.sv
// -----------------------------------------------------------------------------
// bubble_sorter
// In-place stable bubble sort of a DEPTH-word array, ascending or
// descending, with early exit after a pass without swaps.
//   clk : clock
//   rst : synchronous reset, active low
//   bus : bubble_sorter_if slave (host load/readout, start, status)
// Each compare walks LDA -> LDB -> CMP; a swap adds WRA -> WRB.
// The word store write port belongs to the host in IDLE and to the FSM
// otherwise.
// -----------------------------------------------------------------------------
module bubble_sorter
    import sorter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    bubble_sorter_if.slave bus
);

    localparam int AW = calc_aw(DEPTH);
    localparam int CW = calc_cw(DEPTH);
    localparam logic [AW-1:0] LAST_PASS = AW'(DEPTH - 2);

    sort_state_t      state_q, state_d;
    logic [AW-1:0]    i_q, i_d;
    logic [AW-1:0]    pass_q, pass_d;
    logic             swapped_q, swapped_d;
    logic             desc_q, desc_d;
    logic [CW-1:0]    swap_cnt_q, swap_cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic             busy;
    logic             fsm_we;
    logic [WIDTH-1:0] fsm_wdata;
    logic [AW-1:0]    i_next;
    logic [AW-1:0]    op_addr;
    logic [WIDTH-1:0] op_rdata;
    logic             swap_cond;
    logic             advance;
    logic             pass_swapped;
    logic             more_in_pass;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign i_next = i_q + AW'(1);
    assign busy   = (state_q != IDLE);

    // LDB reads and WRB writes the upper element of the pair; every
    // other state addresses the lower one.
    assign op_addr = (state_q == LDB || state_q == WRB) ? i_next : i_q;

    // Strict compares keep equal keys in place, which makes the sort stable.
    assign swap_cond = desc_q ? (a_q < b_q) : (a_q > b_q);

    // The upper bound of i shrinks by one every pass: the tail is final.
    assign more_in_pass = int'(i_q) < (DEPTH - 2 - int'(pass_q));

    // The swap completing in WRB counts toward this pass even though
    // swapped_q is only updated on the same edge.
    assign pass_swapped = swapped_q | (state_q == WRB);

    // Reset has priority over everything, including a pending write-back,
    // so a reset edge never commits half of an exchange it interrupts.
    assign mem_we    = rst & (busy ? fsm_we : bus.wr_en);
    assign mem_waddr = busy ? op_addr   : bus.wr_addr;
    assign mem_wdata = busy ? fsm_wdata : bus.wr_data;

    sort_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .raddr_a_i (op_addr),
        .rdata_a_o (op_rdata),
        .raddr_b_i (bus.rd_addr),
        .rdata_b_o (bus.rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            pass_q     <= '0;
            swapped_q  <= 1'b0;
            desc_q     <= 1'b0;
            swap_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            pass_q     <= pass_d;
            swapped_q  <= swapped_d;
            desc_q     <= desc_d;
            swap_cnt_q <= swap_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        pass_d     = pass_q;
        swapped_d  = swapped_q;
        desc_d     = desc_q;
        swap_cnt_d = swap_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        fsm_we     = 1'b0;
        fsm_wdata  = b_q;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = LDA;
                    i_d        = '0;
                    pass_d     = '0;
                    swapped_d  = 1'b0;
                    swap_cnt_d = '0;
                    desc_d     = bus.descend;
                end
            end
            LDA: begin
                a_d     = op_rdata;
                state_d = LDB;
            end
            LDB: begin
                b_d     = op_rdata;
                state_d = CMP;
            end
            CMP: begin
                if (swap_cond) begin
                    state_d = WRA;
                end else begin
                    advance = 1'b1;
                end
            end
            WRA: begin
                fsm_we    = 1'b1;
                fsm_wdata = b_q;
                state_d   = WRB;
            end
            WRB: begin
                fsm_we     = 1'b1;
                fsm_wdata  = a_q;
                swapped_d  = 1'b1;
                swap_cnt_d = swap_cnt_q + CW'(1);
                advance    = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (more_in_pass) begin
                i_d     = i_next;
                state_d = LDA;
            end else if (!pass_swapped || pass_q == LAST_PASS) begin
                state_d = DONE;
            end else begin
                pass_d    = pass_q + AW'(1);
                i_d       = '0;
                swapped_d = 1'b0;
                state_d   = LDA;
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = (state_q == DONE);
    assign bus.swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_bubble_sorter.sv
// -----------------------------------------------------------------------------
// tb_bubble_sorter
// Two sorter instances: a small 8-bit x 4-word one driven from a table of
// hand-worked vectors plus mid-sort start/write and reset sequences, and a
// 16-bit x 32-word one checked against a reference sort and inversion count.
// -----------------------------------------------------------------------------
module tb_bubble_sorter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bubble_sorter_if #(.WIDTH(8),  .DEPTH(4))  ifs ();
    bubble_sorter_if #(.WIDTH(16), .DEPTH(32)) ifl ();

    logic        start_s = 1'b0;
    logic        start_l = 1'b0;
    logic        wr_en_s = 1'b0;
    logic        wr_en_l = 1'b0;
    logic        descend = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [15:0] wr_data = '0;

    assign ifs.start   = start_s;
    assign ifs.descend = descend;
    assign ifs.wr_en   = wr_en_s;
    assign ifs.wr_addr = wr_addr[1:0];
    assign ifs.wr_data = wr_data[7:0];
    assign ifs.rd_addr = rd_addr[1:0];

    assign ifl.start   = start_l;
    assign ifl.descend = descend;
    assign ifl.wr_en   = wr_en_l;
    assign ifl.wr_addr = wr_addr;
    assign ifl.wr_data = wr_data;
    assign ifl.rd_addr = rd_addr;

    bubble_sorter #(.WIDTH(8), .DEPTH(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (ifs)
    );

    bubble_sorter #(.WIDTH(16), .DEPTH(32)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (ifl)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input bit sel, input int addr, input int data);
        @(negedge clk);
        wr_addr = 5'(addr);
        wr_data = 16'(data);
        if (sel) wr_en_l = 1'b1;
        else     wr_en_s = 1'b1;
        @(negedge clk);
        wr_en_s = 1'b0;
        wr_en_l = 1'b0;
    endtask

    task automatic rd(input bit sel, input int addr, output logic [15:0] d);
        rd_addr = 5'(addr);
        #1;
        d = sel ? ifl.rd_data : {8'h00, ifs.rd_data};
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? ifl.busy : ifs.busy;
    endfunction

    // Counts busy cycles and done pulses, sampling on negedges, until idle.
    task automatic wait_idle(input bit sel, output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 10000; k++) begin
            if (!busy_of(sel)) break;
            busy_n++;
            if (sel ? ifl.done : ifs.done) done_n++;
            @(negedge clk);
        end
        check("sort_finished", {31'd0, busy_of(sel)}, 32'd0);
    endtask

    task automatic pulse_start(input bit sel, input bit desc);
        @(negedge clk);
        descend = desc;
        if (sel) start_l = 1'b1;
        else     start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start_l = 1'b0;
    endtask

    task automatic run_sort(input bit sel, input bit desc, output int busy_n, output int done_n);
        pulse_start(sel, desc);
        wait_idle(sel, busy_n, done_n);
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    typedef struct {
        logic [31:0] in_w;
        bit          desc;
        logic [31:0] exp_w;
        int          swaps;
        int          busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          bn;
        int          dn;
        int          inv;
        int          tmp;
        logic [15:0] d;
        int          ref_a[32];

        vecs[0] = '{pk(4, 3, 2, 1),     1'b0, pk(1, 2, 3, 4),     6, 31};
        vecs[1] = '{pk(1, 2, 3, 4),     1'b1, pk(4, 3, 2, 1),     6, 31};
        vecs[2] = '{pk(2, 2, 1, 1),     1'b0, pk(1, 1, 2, 2),     4, 27};
        vecs[3] = '{pk(1, 2, 3, 4),     1'b0, pk(1, 2, 3, 4),     0, 10};
        vecs[4] = '{pk(3, 1, 2, 255),   1'b0, pk(1, 2, 3, 255),   2, 20};
        vecs[5] = '{pk(0, 255, 128, 128), 1'b1, pk(255, 128, 128, 0), 3, 22};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy_s",  {31'd0, ifs.busy}, 32'd0);
        check("rst_done_s",  {31'd0, ifs.done}, 32'd0);
        check("rst_swaps_s", 32'(ifs.swap_cnt), 32'd0);
        check("rst_busy_l",  {31'd0, ifl.busy}, 32'd0);
        check("rst_swaps_l", 32'(ifl.swap_cnt), 32'd0);
        rst = 1'b1;

        // Table-driven sorts on the 4-word instance
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) wr(1'b0, k, int'(vecs[v].in_w[8*k +: 8]));
            run_sort(1'b0, vecs[v].desc, bn, dn);
            check($sformatf("v%0d_busy", v), 32'(bn), 32'(vecs[v].busy));
            check($sformatf("v%0d_done", v), 32'(dn), 32'd1);
            check($sformatf("v%0d_swaps", v), 32'(ifs.swap_cnt), 32'(vecs[v].swaps));
            for (int k = 0; k < 4; k++) begin
                rd(1'b0, k, d);
                check($sformatf("v%0d_word%0d", v, k), 32'(d), 32'(vecs[v].exp_w[8*k +: 8]));
            end
            $display("vec %0d: busy=%0d swaps=%0d", v, bn, ifs.swap_cnt);
        end

        // start and host write asserted mid-sort are both ignored
        for (int k = 0; k < 4; k++) wr(1'b0, k, 4 - k);
        pulse_start(1'b0, 1'b0);
        bn = 0;
        dn = 0;
        for (int k = 0; k < 200 && ifs.busy; k++) begin
            bn++;
            if (ifs.done) dn++;
            if (bn == 5) begin
                start_s = 1'b1;
                wr_en_s = 1'b1;
                wr_addr = 5'd0;
                wr_data = 16'h00FF;
            end
            if (bn == 7) begin
                start_s = 1'b0;
                wr_en_s = 1'b0;
            end
            @(negedge clk);
        end
        start_s = 1'b0;
        wr_en_s = 1'b0;
        check("ign_busy", 32'(bn), 32'd31);
        check("ign_done", 32'(dn), 32'd1);
        check("ign_swaps", 32'(ifs.swap_cnt), 32'd6);
        check("ign_idle", {31'd0, ifs.busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            rd(1'b0, k, d);
            check($sformatf("ign_word%0d", k), 32'(d), 32'(k + 1));
        end
        $display("ignore-midsort: busy=%0d swaps=%0d", bn, ifs.swap_cnt);

        // Reset during the second swap's WRB: [4,3,2,1] -> [3,4,2,1] -> WRA
        // leaves [3,2,2,1]; the interrupted WRB write is dropped.
        for (int k = 0; k < 4; k++) wr(1'b0, k, 4 - k);
        pulse_start(1'b0, 1'b0);
        bn = 0;
        for (int k = 0; k < 200 && ifs.busy; k++) begin
            bn++;
            if (bn == 10) begin
                check("pre_rst_swaps", 32'(ifs.swap_cnt), 32'd1);
                rst = 1'b0;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        check("mid_rst_reached", 32'(bn), 32'd10);
        check("mid_rst_busy", {31'd0, ifs.busy}, 32'd0);
        check("mid_rst_done", {31'd0, ifs.done}, 32'd0);
        check("mid_rst_swaps", 32'(ifs.swap_cnt), 32'd0);
        rst = 1'b1;
        run_sort(1'b0, 1'b0, bn, dn);
        check("post_rst_busy", 32'(bn), 32'd29);
        check("post_rst_swaps", 32'(ifs.swap_cnt), 32'd5);
        for (int k = 0; k < 4; k++) begin
            rd(1'b0, k, d);
            check($sformatf("post_rst_word%0d", k), 32'(d), 32'(k == 0 ? 1 : (k == 3 ? 3 : 2)));
        end
        $display("reset-midsort: resort busy=%0d swaps=%0d", bn, ifs.swap_cnt);

        // 32-word instance: random data (with duplicates), both directions
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 32; k++) begin
                ref_a[k] = (k % 3 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 65535));
                wr(1'b1, k, ref_a[k]);
            end
            inv = 0;
            for (int x = 0; x < 32; x++)
                for (int y = x + 1; y < 32; y++)
                    if (m == 1 ? (ref_a[x] < ref_a[y]) : (ref_a[x] > ref_a[y])) inv++;
            for (int x = 0; x < 32; x++)
                for (int y = x + 1; y < 32; y++)
                    if (m == 1 ? (ref_a[y] > ref_a[x]) : (ref_a[y] < ref_a[x])) begin
                        tmp      = ref_a[x];
                        ref_a[x] = ref_a[y];
                        ref_a[y] = tmp;
                    end
            run_sort(1'b1, m[0], bn, dn);
            check($sformatf("rand%0d_done", m), 32'(dn), 32'd1);
            check($sformatf("rand%0d_swaps", m), 32'(ifl.swap_cnt), 32'(inv));
            for (int k = 0; k < 32; k++) begin
                rd(1'b1, k, d);
                check($sformatf("rand%0d_word%0d", m, k), 32'(d), 32'(ref_a[k]));
            end
            $display("random %s: busy=%0d swaps=%0d inversions=%0d",
                     m == 1 ? "descending" : "ascending", bn, ifl.swap_cnt, inv);
        end

        // Already-sorted array: one pass of 31 compares, no swaps
        for (int k = 0; k < 32; k++) wr(1'b1, k, 3 * k + 1);
        run_sort(1'b1, 1'b0, bn, dn);
        check("sorted_busy", 32'(bn), 32'd94);
        check("sorted_swaps", 32'(ifl.swap_cnt), 32'd0);
        for (int k = 0; k < 32; k++) begin
            rd(1'b1, k, d);
            check($sformatf("sorted_word%0d", k), 32'(d), 32'(3 * k + 1));
        end
        $display("early-exit: busy=%0d swaps=%0d", bn, ifl.swap_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
